// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared types for the multiplier arbiter
package mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick starting at prio
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   prio,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    // lowest requester overall is the wrap-around fallback
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
    // lowest requester at or above prio takes precedence
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(prio))) begin
        idx = IDX_W'(i);
      end
    end
    grant[idx] = any;
  end

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin sequencer sharing one shift-add multiplier
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int INPUT_SIZE  = 1024,
  parameter int OUTPUT_SIZE = 2 * INPUT_SIZE
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ*INPUT_SIZE-1:0] req_a_in,
  input  logic [NUM_REQ*INPUT_SIZE-1:0] req_b_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  output logic [NUM_REQ-1:0]            resp_valid_out,
  output logic [OUTPUT_SIZE-1:0]        resp_result_out,
  output logic                          busy_out,
  output logic [INPUT_SIZE-1:0]         mult_a_out,
  output logic [INPUT_SIZE-1:0]         mult_b_out,
  output logic                          mult_start_out,
  input  logic                          mult_busy_in,
  input  logic                          mult_valid_in,
  input  logic [OUTPUT_SIZE-1:0]        mult_result_in
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t             state;
  logic [IDX_W-1:0]       prio;
  logic [IDX_W-1:0]       owner;
  logic [INPUT_SIZE-1:0]  op_a;
  logic [INPUT_SIZE-1:0]  op_b;
  logic [OUTPUT_SIZE-1:0] res;

  logic [NUM_REQ-1:0]     pick_grant;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic [INPUT_SIZE-1:0]  win_a;
  logic [INPUT_SIZE-1:0]  win_b;
  logic [NUM_REQ-1:0]     owner_hot;
  logic [IDX_W-1:0]       next_prio;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req   (req_valid_in),
    .prio  (prio),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        win_a = req_a_in[i*INPUT_SIZE +: INPUT_SIZE];
        win_b = req_b_in[i*INPUT_SIZE +: INPUT_SIZE];
      end
    end
  end

  assign owner_hot = NUM_REQ'(1) << owner;
  assign next_prio = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  // the multiplier re-reads its operands every cycle, so they come straight from the holding registers
  assign mult_a_out      = op_a;
  assign mult_b_out      = op_b;
  assign resp_result_out = (|resp_valid_out) ? res : '0;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= IDLE;
      prio           <= '0;
      owner          <= '0;
      op_a           <= '0;
      op_b           <= '0;
      res            <= '0;
      req_ready_out  <= '0;
      resp_valid_out <= '0;
      busy_out       <= 1'b0;
      mult_start_out <= 1'b0;
    end else begin
      req_ready_out  <= '0;
      resp_valid_out <= '0;
      mult_start_out <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            owner         <= pick_idx;
            op_a          <= win_a;
            op_b          <= win_b;
            req_ready_out <= pick_grant;
            busy_out      <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (!mult_busy_in) begin
            mult_start_out <= 1'b1;
            state          <= WAIT;
          end
        end
        WAIT: begin
          // result is only present for this one cycle
          if (mult_valid_in) begin
            res            <= mult_result_in;
            resp_valid_out <= owner_hot;
            state          <= RESPOND;
          end
        end
        RESPOND: begin
          prio     <= next_prio;
          busy_out <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy_out <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - randomized and directed checks of mult_arbiter against a transaction model
module tb_mult_arbiter;

  localparam int N  = 3;
  localparam int W  = 16;
  localparam int OW = 2 * W;

  logic            clk_in = 1'b0;
  logic            rst_in = 1'b1;
  logic [N-1:0]    req_valid_in = '0;
  logic [N*W-1:0]  req_a_in = '0;
  logic [N*W-1:0]  req_b_in = '0;
  logic [N-1:0]    req_ready_out;
  logic [N-1:0]    resp_valid_out;
  logic [OW-1:0]   resp_result_out;
  logic            busy_out;
  logic [W-1:0]    mult_a_out;
  logic [W-1:0]    mult_b_out;
  logic            mult_start_out;
  logic            mult_busy_in;
  logic            mult_valid_in;
  logic [OW-1:0]   mult_result_in;

  mult_arbiter #(.NUM_REQ(N), .INPUT_SIZE(W), .OUTPUT_SIZE(OW)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .req_valid_in    (req_valid_in),
    .req_a_in        (req_a_in),
    .req_b_in        (req_b_in),
    .req_ready_out   (req_ready_out),
    .resp_valid_out  (resp_valid_out),
    .resp_result_out (resp_result_out),
    .busy_out        (busy_out),
    .mult_a_out      (mult_a_out),
    .mult_b_out      (mult_b_out),
    .mult_start_out  (mult_start_out),
    .mult_busy_in    (mult_busy_in),
    .mult_valid_in   (mult_valid_in),
    .mult_result_in  (mult_result_in)
  );

  initial forever #5 clk_in = ~clk_in;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bitlen(logic [W-1:0] v);
    int n = 0;
    for (int i = 0; i < W; i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  function automatic int rr_pick(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // shift-add multiplier stand-in: latency follows bit length of b, result held for one cycle
  bit rand_mode = 0;
  int mcnt = 0, mtail = 0, mtail_len = 0;
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mult_busy_in <= 1'b0; mult_valid_in <= 1'b0; mult_result_in <= '0;
      mcnt <= 0; mtail <= 0;
    end else begin
      mult_valid_in  <= 1'b0;
      mult_result_in <= '0;
      if (mcnt != 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) begin
          mult_valid_in  <= 1'b1;
          mult_result_in <= {{W{1'b0}}, mult_a_out} * {{W{1'b0}}, mult_b_out};
          if (mtail_len == 0) mult_busy_in <= 1'b0;
          else mtail <= mtail_len;
        end
      end else if (mtail != 0) begin
        mtail <= mtail - 1;
        if (mtail == 1) mult_busy_in <= 1'b0;
        if ($urandom_range(0, 2) == 0) begin
          mult_valid_in <= 1'b1; mult_result_in <= OW'($urandom);
        end
      end else if (mult_start_out) begin
        mult_busy_in <= 1'b1;
        mcnt         <= bitlen(mult_b_out) + 1;
        mtail_len    <= $urandom_range(0, 3);
      end else if (rand_mode && !busy_out && $urandom_range(0, 7) == 0) begin
        mult_valid_in <= 1'b1; mult_result_in <= OW'($urandom);
      end
    end
  end

  // transaction-level reference: accept, start, capture, respond, then rotate priority
  bit m_in = 0, m_need_start = 0, m_waiting = 0, m_responding = 0;
  int m_prio = 0, m_owner = 0;
  logic [W-1:0]  m_opa = '0, m_opb = '0;
  logic [N-1:0]  exp_ready = '0, exp_resp = '0;
  logic          exp_start = 0, exp_busy = 0;
  logic [OW-1:0] exp_result = '0;

  always @(negedge clk_in) begin
    int w;
    if (rst_in) begin
      exp_ready = '0; exp_resp = '0; exp_start = 0; exp_busy = 0; exp_result = '0;
      m_opa = '0; m_opb = '0;
    end
    chk("ready", req_ready_out, exp_ready);
    chk("start", mult_start_out, exp_start);
    chk("resp_valid", resp_valid_out, exp_resp);
    chk("resp_result", resp_result_out, exp_result);
    chk("busy", busy_out, exp_busy);
    chk("mult_a", mult_a_out, m_opa);
    chk("mult_b", mult_b_out, m_opb);
    if (rst_in) begin
      m_in = 0; m_need_start = 0; m_waiting = 0; m_responding = 0; m_prio = 0; m_owner = 0;
    end else begin
      exp_ready = '0; exp_resp = '0; exp_start = 0; exp_result = '0;
      if (m_responding) begin
        m_responding = 0; m_in = 0; m_prio = (m_owner + 1) % N;
      end else if (!m_in) begin
        if (req_valid_in != '0) begin
          w = rr_pick(req_valid_in, m_prio);
          m_in = 1; m_need_start = 1; m_owner = w;
          m_opa = req_a_in[w*W +: W]; m_opb = req_b_in[w*W +: W];
          exp_ready = N'(1) << w;
        end
      end else if (m_need_start) begin
        if (!mult_busy_in) begin exp_start = 1; m_need_start = 0; m_waiting = 1; end
      end else if (m_waiting) begin
        if (mult_valid_in) begin
          exp_resp = N'(1) << m_owner;
          exp_result = {{W{1'b0}}, m_opa} * {{W{1'b0}}, m_opb};
          m_waiting = 0; m_responding = 1;
        end
      end
      exp_busy = m_in;
    end
  end

  logic [N-1:0] pend = '0, rdy_seen = '0, got_rdy = '0;
  logic [W-1:0] pend_a [N];
  logic [W-1:0] pend_b [N];
  int rdy_cnt = 0, start_cnt = 0;
  int resp_idx_q [$];
  logic [OW-1:0] resp_val_q [$];

  task automatic tick();
    logic [W-1:0] mask;
    @(negedge clk_in);
    rdy_seen |= req_ready_out;
    got_rdy  |= req_ready_out;
    if (req_ready_out != '0) rdy_cnt++;
    if (mult_start_out) start_cnt++;
    for (int i = 0; i < N; i++)
      if (resp_valid_out[i]) begin resp_idx_q.push_back(i); resp_val_q.push_back(resp_result_out); end
    @(posedge clk_in);
    #2;
    for (int i = 0; i < N; i++) begin
      if (req_valid_in[i] && rdy_seen[i]) begin
        req_valid_in[i] = 1'b0;
        req_a_in[i*W +: W] = W'($urandom);
        req_b_in[i*W +: W] = W'($urandom);
      end else if (rand_mode && req_valid_in[i] && $urandom_range(0, 23) == 0) begin
        req_valid_in[i] = 1'b0;
      end
      rdy_seen[i] = 1'b0;
      if (!req_valid_in[i] && pend[i]) begin
        req_valid_in[i] = 1'b1; req_a_in[i*W +: W] = pend_a[i]; req_b_in[i*W +: W] = pend_b[i];
        pend[i] = 1'b0;
      end else if (!req_valid_in[i] && rand_mode && $urandom_range(0, 2) == 0) begin
        mask = 16'hFFFF >> $urandom_range(0, 16);
        req_valid_in[i] = 1'b1;
        req_a_in[i*W +: W] = W'($urandom);
        req_b_in[i*W +: W] = W'($urandom) & mask;
      end
    end
  endtask

  task automatic request(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    pend_a[i] = a; pend_b[i] = b; pend[i] = 1'b1;
  endtask

  task automatic wait_resp(input int n, input int budget);
    int c = 0;
    while (resp_idx_q.size() < n && c < budget) begin tick(); c++; end
    chk("resp_count", resp_idx_q.size(), n);
  endtask

  task automatic pop_resp(input string name, input int idx, input logic [OW-1:0] val);
    if (resp_idx_q.size() == 0) begin
      chk({name, "_present"}, 0, 1);
    end else begin
      chk({name, "_owner"}, resp_idx_q.pop_front(), idx);
      chk({name, "_value"}, resp_val_q.pop_front(), val);
    end
  endtask

  initial begin
    int c, r0, s0, n0;
    tick(); tick();
    chk("reset_ready", req_ready_out, 0);
    chk("reset_resp", resp_valid_out, 0);
    chk("reset_busy", busy_out, 0);
    chk("reset_start", mult_start_out, 0);
    rst_in = 1'b0;
    tick();

    // contention from reset: 0 then 1, and 0 again after an immediate re-raise
    request(0, 16'd3, 16'd5);
    request(1, 16'd7, 16'd9);
    got_rdy = '0; c = 0;
    while (!got_rdy[0] && c < 50) begin tick(); c++; end
    chk("contention_first_accept", got_rdy, 3'b001);
    request(0, 16'd2, 16'd4);
    wait_resp(3, 300);
    pop_resp("cont0", 0, 32'd15);
    pop_resp("cont1", 1, 32'd63);
    pop_resp("cont2", 0, 32'd8);

    // single request
    repeat (3) tick();
    r0 = rdy_cnt; s0 = start_cnt;
    request(0, 16'd13, 16'd11);
    wait_resp(1, 100);
    repeat (3) tick();
    chk("single_ready_pulses", rdy_cnt - r0, 1);
    chk("single_start_pulses", start_cnt - s0, 1);
    chk("single_busy_done", busy_out, 0);
    pop_resp("single", 0, 32'd143);

    // zero operands, each with exactly one response
    request(1, 16'hFFFF, 16'd0);
    wait_resp(1, 100);
    repeat (10) tick();
    chk("b0_once", resp_idx_q.size(), 1);
    pop_resp("b0", 1, 32'd0);
    request(2, 16'd0, 16'hFF);
    wait_resp(1, 100);
    pop_resp("a0", 2, 32'd0);

    // width extremes
    request(0, 16'hFFFF, 16'hFFFF);
    wait_resp(1, 100);
    pop_resp("max", 0, 32'hFFFE_0001);

    // asynchronous reset while a long multiply is in flight
    repeat (2) tick();
    n0 = start_cnt;
    request(2, 16'h1234, 16'hFFFF);
    c = 0;
    while (start_cnt == n0 && c < 50) begin tick(); c++; end
    chk("midwait_started", start_cnt - n0, 1);
    repeat (3) tick();
    #1 rst_in = 1'b1;
    #1;
    chk("async_ready", req_ready_out, 0);
    chk("async_resp", resp_valid_out, 0);
    chk("async_result", resp_result_out, 0);
    chk("async_busy", busy_out, 0);
    chk("async_start", mult_start_out, 0);
    chk("async_mult_a", mult_a_out, 0);
    chk("async_mult_b", mult_b_out, 0);
    tick(); tick();
    rst_in = 1'b0;
    repeat (30) tick();
    chk("dropped_no_resp", resp_idx_q.size(), 0);
    request(0, 16'd21, 16'd2);
    request(1, 16'd5, 16'd6);
    wait_resp(2, 200);
    pop_resp("after_rst0", 0, 32'd42);
    pop_resp("after_rst1", 1, 32'd30);

    // randomized traffic, spurious valids and withdrawals
    rand_mode = 1;
    repeat (3000) tick();
    rand_mode = 0;
    c = 0;
    while ((req_valid_in != '0 || busy_out) && c < 600) begin tick(); c++; end
    chk("drain_idle", {busy_out, req_valid_in}, 0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
